clock_generation: RTL and testbench
===================================

Name: clock_generation

Overview:
- Transmit-side counterpart of the clock recovery path. Drives a primary/secondary clock pin pair in any clks_alot_p::input_mode_s mode: single, differential or quadrature, each continuous or pausable.
- Output is built from a programmable half-period counter. The pins always start and stop at the mode's idle phase, so a downstream recovery block never sees a runt edge or a diff violation.
- Sits in the same domain as recovery. Its pins feed pad drivers or the loopback test path.

Parameters:
- HALF_PERIOD_WIDTH, 16: width of the step counter and of half_period_i.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  system clock domain bundle. .clk is the single clock. .sync_rst is the synchronous, active-high reset.
- drive_en_i  input  1  enables clock generation.
- drive_mode_i  input  clks_alot_p::input_mode_s  requested output mode. Latched only on the IDLE->RUN transition.
- half_period_i  input  HALF_PERIOD_WIDTH  sys clocks per phase step (a half period in single/diff, a quarter period in quad). A value of 0 is treated as 1. Re-sampled at every step.
- pause_req_i  input  1  pause request. Honoured only in *_PAUSABLE modes.
- drive_pins_o  output  clks_alot_p::recovery_pins_s  registered primary/secondary pin levels.
- rising_edge_o  output  1  one-cycle pulse, same cycle primary goes 0->1.
- falling_edge_o  output  1  one-cycle pulse, same cycle primary goes 1->0.
- running_o  output  1  high in RUN and STOPPING.
- paused_o  output  1  high in PAUSED.

Behaviour:
- Reset: state IDLE, counter 0, latched mode SINGLE_CONTINUOUS, primary 0, secondary 0, all pulses and flags 0.
- Idle phase (p,s) per mode:
  - single: (0,0)
  - diff: (0,1)
  - quad: (0,0)
- In IDLE, pins are driven to the idle phase of drive_mode_i, combinationally selected and registered once.
- Step sequence per mode:
  - single: p toggles each step; s held 0.
  - diff: p toggles each step; s = ~p in the same cycle (never p==s).
  - quad: (p,s) advances 00->10->11->01->00. Exactly one pin changes per step, and primary leads secondary by 90 degrees.
- Counter:
  - Increments each cycle in RUN and STOPPING.
  - At count == max(half_period_i,1)-1: a step occurs on the next register update, and the counter clears.
- States:
  - IDLE -> RUN when drive_en_i=1. Mode latches and the counter clears.
  - RUN -> STOPPING when drive_en_i=0, or when pause_req_i=1 in a pausable mode.
  - STOPPING keeps stepping until the pins reach the idle phase. If the pins are already at the idle phase on entry, leave STOPPING that same cycle.
  - From STOPPING, go to IDLE if drive_en_i=0; otherwise go to PAUSED.
  - PAUSED: pins hold the idle phase and the counter is held at 0.
    - pause_req_i=0 with drive_en_i=1 -> RUN; the first step comes a full half_period later.
    - drive_en_i=0 -> IDLE.
  - In STOPPING, drive_en_i=0 takes priority over the pause target.
  - pause_req_i deasserted during STOPPING does not abort the stop. Completion to idle is mandatory.
- Continuous modes: pause_req_i is ignored entirely.
- Latency:
  - drive_en_i rises in cycle t -> RUN in t+1 -> first edge registered at t+1+N, where N = max(half_period_i,1).
  - Steady state: one step every N cycles.
- Mode change while RUN/STOPPING/PAUSED is ignored. The new mode applies at the next IDLE->RUN.
- Edge pulses are registered alongside the pins and are zero in every cycle without a primary transition. They are also zero on the IDLE re-drive when the mode changes.
- sync_rst asserted mid-operation: next cycle matches the reset state (pins 0,0). Abrupt truncation is allowed only on reset.

Test Plan:
- SINGLE_CONTINUOUS, half_period_i=3, drive_en_i 0->1 at t: primary rises at t+4, falls at t+7, period 6. secondary stays 0. rising_edge_o pulses at t+4, t+10.
- DIF_CONTINUOUS, half_period_i=2: p==~s every cycle after the idle re-drive. Drop drive_en_i while p=1: exactly one more step, then IDLE with (0,1) and running_o=0.
- QUAD_PAUSABLE, half_period_i=1: sequence 00,10,11,01,00 on consecutive cycles. Assert pause_req_i at phase 11: steps to 01 then 00, then paused_o=1. Release: RUN, next step to 10 after 1 cycle.
- SINGLE_CONTINUOUS with pause_req_i held high: clock keeps toggling and paused_o never asserts.
- half_period_i=0: behaves as 1 (toggle every cycle). Change half_period_i 4->2 mid-run: the new spacing takes effect after the current step.
- sync_rst pulsed mid-RUN in DIF mode with p=1: next cycle pins (0,0), state IDLE, all pulses 0. Change drive_mode_i to QUAD mid-run: stepping stays DIF until the next IDLE->RUN.

Source files
------------

// File: rtl/clock_generation.sv
// Transmit-side clock pin generator: drives single, differential or quadrature pin pairs
// from a programmable half-period step counter, always starting and stopping at idle phase.
package common_p;
    typedef struct packed {
        logic clk;
        logic sync_rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    typedef enum logic [2:0] {
        SINGLE_CONTINUOUS,
        SINGLE_PAUSABLE,
        DIF_CONTINUOUS,
        DIF_PAUSABLE,
        QUAD_CONTINUOUS,
        QUAD_PAUSABLE
    } input_mode_s;

    typedef struct packed {
        logic primary;
        logic secondary;
    } recovery_pins_s;
endpackage

module clock_generation #(
    parameter int unsigned HALF_PERIOD_WIDTH = 16
) (
    input  common_p::clk_dom_s           sys_dom_i,
    input  logic                         drive_en_i,
    input  clks_alot_p::input_mode_s     drive_mode_i,
    input  logic [HALF_PERIOD_WIDTH-1:0] half_period_i,
    input  logic                         pause_req_i,
    output clks_alot_p::recovery_pins_s  drive_pins_o,
    output logic                         rising_edge_o,
    output logic                         falling_edge_o,
    output logic                         running_o,
    output logic                         paused_o
);
    import clks_alot_p::*;

    localparam logic [HALF_PERIOD_WIDTH-1:0] ONE = HALF_PERIOD_WIDTH'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING, ST_PAUSED} state_e;

    state_e                       state_q, state_d;
    input_mode_s                  mode_q, mode_d;
    recovery_pins_s               pins_q, pins_d;
    logic                         rise_q, rise_d, fall_q, fall_d;
    logic [HALF_PERIOD_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d, hp_eff;
    logic                         pausable, at_idle, step;

    function automatic recovery_pins_s idle_phase(input input_mode_s m);
        recovery_pins_s ph;
        ph = '0;
        if (m == DIF_CONTINUOUS || m == DIF_PAUSABLE) ph.secondary = 1'b1;
        return ph;
    endfunction

    function automatic recovery_pins_s step_phase(input input_mode_s m, input recovery_pins_s cur);
        recovery_pins_s nxt;
        case (m)
            SINGLE_CONTINUOUS, SINGLE_PAUSABLE: begin
                nxt.primary   = ~cur.primary;
                nxt.secondary = 1'b0;
            end
            DIF_CONTINUOUS, DIF_PAUSABLE: begin
                nxt.primary   = ~cur.primary;
                nxt.secondary = cur.primary;
            end
            default: begin
                nxt.primary   = ~cur.secondary;
                nxt.secondary = cur.primary;
            end
        endcase
        return nxt;
    endfunction

    assign hp_eff   = (half_period_i == '0) ? ONE : half_period_i;
    assign pausable = (mode_q == SINGLE_PAUSABLE) || (mode_q == DIF_PAUSABLE) ||
                      (mode_q == QUAD_PAUSABLE);
    assign at_idle  = (pins_q == idle_phase(mode_q));
    // The step spacing is captured at each step so a new half_period only shapes the next interval.
    assign step     = ((state_q == ST_RUN) || (state_q == ST_STOPPING && !at_idle)) &&
                      (cnt_q == period_q - ONE);

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= SINGLE_CONTINUOUS;
            pins_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= ONE;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pins_q   <= pins_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (drive_en_i) state_d = ST_RUN;
            ST_RUN:      if (!drive_en_i || (pause_req_i && pausable)) state_d = ST_STOPPING;
            ST_STOPPING: if (at_idle) state_d = drive_en_i ? ST_PAUSED : ST_IDLE;
            ST_PAUSED: begin
                if (!drive_en_i)                     state_d = ST_IDLE;
                else if (!pause_req_i || !pausable)  state_d = ST_RUN;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        pins_d   = pins_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        case (state_q)
            ST_IDLE: begin
                mode_d   = drive_mode_i;
                pins_d   = idle_phase(drive_mode_i);
                cnt_d    = '0;
                period_d = hp_eff;
            end
            ST_RUN, ST_STOPPING: begin
                if (step) begin
                    pins_d   = step_phase(mode_q, pins_q);
                    cnt_d    = '0;
                    period_d = hp_eff;
                end else if (state_q == ST_RUN || !at_idle) begin
                    cnt_d = cnt_q + ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d    = '0;
                period_d = hp_eff;
            end
        endcase
        rise_d = (state_q != ST_IDLE) && !pins_q.primary &&  pins_d.primary;
        fall_d = (state_q != ST_IDLE) &&  pins_q.primary && !pins_d.primary;
    end

    assign drive_pins_o   = pins_q;
    assign rising_edge_o  = rise_q;
    assign falling_edge_o = fall_q;
    assign running_o      = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    assign paused_o       = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_clock_generation.sv
// Directed and randomized checks of clock_generation against a phase-index reference model.
module tb_clock_generation;
    import clks_alot_p::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        en = 1'b0;
    logic                        pr = 1'b0;
    logic [15:0]                 hp = 16'd3;
    input_mode_s                 mode = SINGLE_CONTINUOUS;
    common_p::clk_dom_s          sys_dom;
    recovery_pins_s              pins;
    logic                        rise, fall, running, paused;

    int vectors = 0;
    int miscompares = 0;

    // reference model: 0 idle, 1 run, 2 stopping, 3 paused
    int          mst = 0;
    input_mode_s mmode = SINGLE_CONTINUOUS;
    int          ph = 0;
    int          left = 1;
    logic        exp_p = 1'b0, exp_s = 1'b0, exp_rise = 1'b0, exp_fall = 1'b0;

    assign sys_dom = {clk, rst};
    always #5 clk = ~clk;

    clock_generation #(.HALF_PERIOD_WIDTH(16)) dut (
        .sys_dom_i      (sys_dom),
        .drive_en_i     (en),
        .drive_mode_i   (mode),
        .half_period_i  (hp),
        .pause_req_i    (pr),
        .drive_pins_o   (pins),
        .rising_edge_o  (rise),
        .falling_edge_o (fall),
        .running_o      (running),
        .paused_o       (paused)
    );

    function automatic bit is_quad(input input_mode_s m);
        return (m == QUAD_CONTINUOUS) || (m == QUAD_PAUSABLE);
    endfunction

    function automatic bit is_diff(input input_mode_s m);
        return (m == DIF_CONTINUOUS) || (m == DIF_PAUSABLE);
    endfunction

    function automatic bit is_pausable(input input_mode_s m);
        return (m == SINGLE_PAUSABLE) || (m == DIF_PAUSABLE) || (m == QUAD_PAUSABLE);
    endfunction

    function automatic logic [1:0] phase_pins(input input_mode_s m, input int k);
        logic [1:0] quad_tbl [4];
        quad_tbl = '{2'b00, 2'b10, 2'b11, 2'b01};
        if (is_quad(m)) return quad_tbl[k % 4];
        if (is_diff(m)) return (k % 2 == 1) ? 2'b10 : 2'b01;
        return (k % 2 == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic advance(input int n);
        if (left <= 1) begin
            ph   = (ph + 1) % (is_quad(mmode) ? 4 : 2);
            left = n;
        end else begin
            left = left - 1;
        end
    endtask

    task automatic model_update();
        int         n;
        logic       op;
        logic [1:0] pp;
        n  = (hp == 16'd0) ? 1 : int'(hp);
        op = exp_p;
        if (rst) begin
            mst = 0; mmode = SINGLE_CONTINUOUS; ph = 0; left = 1;
        end else begin
            case (mst)
                0: begin
                    mmode = mode; ph = 0;
                    if (en) begin mst = 1; left = n; end
                end
                1: begin
                    advance(n);
                    if (!en || (pr && is_pausable(mmode))) mst = 2;
                end
                2: begin
                    if (ph == 0) mst = en ? 3 : 0;
                    else         advance(n);
                end
                default: begin
                    if (!en) mst = 0;
                    else if (!pr || !is_pausable(mmode)) begin mst = 1; left = n; end
                end
            endcase
        end
        pp       = phase_pins(mmode, ph);
        exp_p    = pp[1];
        exp_s    = pp[0];
        exp_rise = !rst && !op && exp_p;
        exp_fall = !rst && op && !exp_p;
    endtask

    task automatic tick(input string tag);
        logic [5:0] got_v, exp_v;
        @(posedge clk);
        model_update();
        #1;
        got_v = {pins.primary, pins.secondary, rise, fall, running, paused};
        exp_v = {exp_p, exp_s, exp_rise, exp_fall, (mst == 1 || mst == 2), (mst == 3)};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (p s rise fall run paused)", tag, got_v, exp_v);
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic wait_pins(input logic [1:0] target, input int limit, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick(tag);
            if ({pins.primary, pins.secondary} === target) found = 1'b1;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed pins %b expected %b within %0d cycles",
                   tag, {pins.primary, pins.secondary}, target, limit);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    initial begin
        int first_rise, first_fall, paused_seen;

        ticks(2, "reset");
        check("reset_state", {2'b00, pins.primary, pins.secondary, rise, fall, running, paused}, 8'd0);
        rst = 1'b0;
        ticks(2, "idle_single");

        en = 1'b1;
        first_rise = 0; first_fall = 0;
        for (int i = 1; i <= 12; i++) begin
            tick("single_hp3");
            if (rise && first_rise == 0) first_rise = i;
            if (fall && first_fall == 0) first_fall = i;
        end
        check("single_first_rise", 8'(first_rise), 8'd4);
        check("single_first_fall", 8'(first_fall), 8'd7);
        en = 1'b0;
        ticks(10, "single_stop");

        mode = DIF_CONTINUOUS; hp = 16'd2;
        ticks(2, "diff_idle");
        en = 1'b1;
        wait_pins(2'b10, 20, "diff_run");
        en = 1'b0;
        ticks(6, "diff_stop");
        check("diff_idle_pins", {4'd0, pins.primary, pins.secondary, running, paused}, 8'b0000_0100);

        mode = QUAD_PAUSABLE; hp = 16'd1;
        ticks(2, "quad_idle");
        en = 1'b1;
        wait_pins(2'b11, 10, "quad_run");
        pr = 1'b1;
        ticks(5, "quad_pause");
        check("quad_paused", {7'd0, paused}, 8'd1);
        pr = 1'b0;
        ticks(6, "quad_resume");
        en = 1'b0;
        ticks(8, "quad_stop");

        mode = SINGLE_CONTINUOUS; hp = 16'd2;
        ticks(2, "cont_idle");
        en = 1'b1; pr = 1'b1;
        paused_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick("cont_pause_ignored");
            if (paused) paused_seen++;
        end
        check("cont_never_paused", 8'(paused_seen), 8'd0);
        pr = 1'b0;

        hp = 16'd0;
        ticks(6, "hp_zero");
        hp = 16'd4;
        ticks(10, "hp_four");
        hp = 16'd2;
        ticks(10, "hp_two");
        en = 1'b0;
        ticks(8, "hp_stop");

        mode = DIF_CONTINUOUS; hp = 16'd3;
        ticks(2, "rst_idle");
        en = 1'b1;
        wait_pins(2'b10, 20, "rst_run");
        rst = 1'b1;
        tick("mid_reset");
        check("mid_reset_state", {2'b00, pins.primary, pins.secondary, rise, fall, running, paused}, 8'd0);
        rst = 1'b0;
        ticks(4, "diff_restart");
        mode = QUAD_CONTINUOUS;
        ticks(12, "mode_change_ignored");
        en = 1'b0;
        ticks(10, "final_stop");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0)  pr = ~pr;
            if ($urandom_range(0, 19) == 0) mode = input_mode_s'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0)  hp = 16'($urandom_range(0, 4));
            rst = ($urandom_range(0, 99) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
